// File: rtl/iecdrv_sd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : iecdrv_sd_arbiter_if
// Description : Per-drive SD request ports and the shared host sector channel.
// Revision    : 1.0 - initial release
// ============================================================================
interface iecdrv_sd_arbiter_if #(
    parameter int NDR = 2
);
    logic [NDR-1:0][31:0] drv_lba;
    logic [NDR-1:0]       drv_rd;
    logic [NDR-1:0]       drv_wr;
    logic [NDR-1:0]       drv_ack;
    logic [NDR-1:0][7:0]  drv_buff_din;
    logic [31:0]          host_lba;
    logic                 host_rd;
    logic                 host_wr;
    logic                 host_ack;
    logic [7:0]           host_buff_din;
    logic                 busy;

    // Drive array and host side of the channel.
    modport master (
        output drv_lba, drv_rd, drv_wr, drv_buff_din, host_ack,
        input  drv_ack, host_lba, host_rd, host_wr, host_buff_din, busy
    );

    // Arbiter side.
    modport slave (
        input  drv_lba, drv_rd, drv_wr, drv_buff_din, host_ack,
        output drv_ack, host_lba, host_rd, host_wr, host_buff_din, busy
    );
endinterface
`default_nettype wire

// File: rtl/iecdrv_sd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : iecdrv_sd_arbiter
// Description : Round-robin serialiser of per-drive SD sector requests onto
//               the single host sector channel.
// Revision    : 1.0 - initial release
// ============================================================================
module iecdrv_sd_arbiter #(
    parameter int NDR     = 2,
    parameter int TIMEOUT = 0
) (
    input  wire logic          clk,
    input  wire logic          reset,
    iecdrv_sd_arbiter_if.slave bus
);
    localparam int SELW = (NDR > 1) ? $clog2(NDR) : 1;
    localparam logic [SELW:0] c_ndr = (SELW + 1)'(NDR);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    state_t          r_state, w_state;
    logic [SELW-1:0] r_sel, w_sel;
    logic [SELW-1:0] r_rr_ptr, w_rr_ptr;
    logic [31:0]     r_host_lba, w_host_lba;
    logic            r_host_rd, w_host_rd;
    logic            r_host_wr, w_host_wr;
    logic [NDR-1:0]  r_drv_ack, w_drv_ack;
    logic [15:0]     r_tmo, w_tmo;

    logic            w_found;
    logic [SELW-1:0] w_pick;
    logic            w_pick_rd;
    logic [SELW:0]   w_cand;
    logic [SELW:0]   w_sel_inc;
    logic            w_sel_req;
    logic            w_tmo_hit;

    // Round-robin scan starting at r_rr_ptr; first requester wins.
    always_comb begin
        w_found   = 1'b0;
        w_pick    = '0;
        w_pick_rd = 1'b0;
        w_cand    = '0;
        for (int k = 0; k < NDR; k++) begin
            w_cand = {1'b0, r_rr_ptr} + (SELW + 1)'(k);
            if (w_cand >= c_ndr) begin
                w_cand = w_cand - c_ndr;
            end
            if (!w_found && (bus.drv_rd[w_cand[SELW-1:0]] || bus.drv_wr[w_cand[SELW-1:0]])) begin
                w_found   = 1'b1;
                w_pick    = w_cand[SELW-1:0];
                w_pick_rd = bus.drv_rd[w_cand[SELW-1:0]];
            end
        end
    end

    always_comb begin
        w_sel_inc = {1'b0, r_sel} + {{SELW{1'b0}}, 1'b1};
        if (w_sel_inc >= c_ndr) begin
            w_sel_inc = '0;
        end
    end

    assign w_sel_req = bus.drv_rd[r_sel] | bus.drv_wr[r_sel];
    assign w_tmo     = (r_state != ST_REQ) ? 16'd0 :
                       (r_tmo == 16'hFFFF) ? r_tmo : r_tmo + 16'd1;
    // Abort once the count of elapsed REQ cycles reaches TIMEOUT.
    assign w_tmo_hit = (TIMEOUT > 0) && ({16'd0, w_tmo} >= 32'(TIMEOUT));

    always_comb begin
        w_state    = r_state;
        w_sel      = r_sel;
        w_rr_ptr   = r_rr_ptr;
        w_host_lba = r_host_lba;
        w_host_rd  = r_host_rd;
        w_host_wr  = r_host_wr;
        w_drv_ack  = r_drv_ack;
        case (r_state)
            ST_IDLE: begin
                w_drv_ack = '0;
                w_host_rd = 1'b0;
                w_host_wr = 1'b0;
                if (w_found) begin
                    w_sel      = w_pick;
                    w_host_lba = bus.drv_lba[w_pick];
                    w_host_rd  = w_pick_rd;
                    w_host_wr  = !w_pick_rd;
                    w_state    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.host_ack) begin
                    w_host_rd        = 1'b0;
                    w_host_wr        = 1'b0;
                    w_drv_ack        = '0;
                    w_drv_ack[r_sel] = 1'b1;
                    w_state          = ST_XFER;
                end else if (!w_sel_req || w_tmo_hit) begin
                    w_host_rd = 1'b0;
                    w_host_wr = 1'b0;
                    w_state   = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (!bus.host_ack) begin
                    w_drv_ack = '0;
                    w_rr_ptr  = w_sel_inc[SELW-1:0];
                    w_state   = ST_IDLE;
                end
            end
            default: begin
                w_drv_ack = '0;
                w_host_rd = 1'b0;
                w_host_wr = 1'b0;
                w_state   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_sel      <= '0;
            r_rr_ptr   <= '0;
            r_host_lba <= '0;
            r_host_rd  <= 1'b0;
            r_host_wr  <= 1'b0;
            r_drv_ack  <= '0;
            r_tmo      <= '0;
        end else begin
            r_state    <= w_state;
            r_sel      <= w_sel;
            r_rr_ptr   <= w_rr_ptr;
            r_host_lba <= w_host_lba;
            r_host_rd  <= w_host_rd;
            r_host_wr  <= w_host_wr;
            r_drv_ack  <= w_drv_ack;
            r_tmo      <= w_tmo;
        end
    end

    assign bus.drv_ack       = r_drv_ack;
    assign bus.host_lba      = r_host_lba;
    assign bus.host_rd       = r_host_rd;
    assign bus.host_wr       = r_host_wr;
    assign bus.busy          = (r_state != ST_IDLE);
    assign bus.host_buff_din = bus.drv_buff_din[r_sel];
endmodule
`default_nettype wire

// File: tb/tb_iecdrv_sd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_iecdrv_sd_arbiter
// Description : Directed bench: NDR=2 vector table plus NDR=4/TIMEOUT=16
//               sequences for round robin, buffer mux, cancel and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iecdrv_sd_arbiter;
    logic clk    = 1'b0;
    logic reset2 = 1'b1;
    logic reset4 = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;
    int   overlap = 0;

    localparam logic [31:0] L0 = 32'h0000_1234;
    localparam logic [31:0] L1 = 32'hABCD_0001;
    localparam logic [7:0]  B0 = 8'h11;
    localparam logic [7:0]  B1 = 8'h22;

    iecdrv_sd_arbiter_if #(.NDR(2)) if2 ();
    iecdrv_sd_arbiter_if #(.NDR(4)) if4 ();

    iecdrv_sd_arbiter #(.NDR(2), .TIMEOUT(0)) u_dut2 (
        .clk   (clk),
        .reset (reset2),
        .bus   (if2.slave)
    );

    iecdrv_sd_arbiter #(.NDR(4), .TIMEOUT(16)) u_dut4 (
        .clk   (clk),
        .reset (reset4),
        .bus   (if4.slave)
    );

    always #5 clk = ~clk;

    // A request must never still be raised once the drive has been acknowledged.
    always @(negedge clk) begin
        if ((if4.host_wr || if4.host_rd) && (if4.drv_ack != 4'b0000)) overlap++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    typedef struct packed {
        logic        rst;
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic        ack;
        logic        e_rd;
        logic        e_wr;
        logic [1:0]  e_ack;
        logic        e_busy;
        logic [31:0] e_lba;
        logic [7:0]  e_buf;
    } vec_t;

    vec_t vecs [26];

    function automatic vec_t mk(logic rst, logic [1:0] rd, logic [1:0] wr, logic ack,
                                logic erd, logic ewr, logic [1:0] eack, logic ebusy,
                                logic [31:0] elba, logic [7:0] ebuf);
        vec_t v;
        v.rst = rst; v.rd = rd; v.wr = wr; v.ack = ack;
        v.e_rd = erd; v.e_wr = ewr; v.e_ack = eack; v.e_busy = ebusy;
        v.e_lba = elba; v.e_buf = ebuf;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Host model for the NDR=4 instance: wait for a grant, ack it, finish it.
    task automatic serve4(input bit drop, output int idx);
        int n;
        idx = -1;
        n   = 0;
        while (!(if4.host_rd || if4.host_wr) && n < 40) begin
            tick();
            n++;
        end
        if (!(if4.host_rd || if4.host_wr)) return;
        idx = int'(if4.host_lba - 32'h100);
        repeat (2) tick();
        if4.host_ack = 1'b1;
        tick();
        if (drop && idx >= 0 && idx < 4) if4.drv_wr[idx] = 1'b0;
        repeat (2) tick();
        if4.host_ack = 1'b0;
        tick();
    endtask

    initial begin
        int idx;
        int errs;
        int cnt;

        if2.drv_lba      = '{L1, L0};
        if2.drv_buff_din = '{B1, B0};
        if2.drv_rd       = '0;
        if2.drv_wr       = '0;
        if2.host_ack     = 1'b0;
        if4.drv_lba      = '{32'h103, 32'h102, 32'h101, 32'h100};
        if4.drv_buff_din = '{8'hD3, 8'hC2, 8'hB1, 8'hA0};
        if4.drv_rd       = '0;
        if4.drv_wr       = '0;
        if4.host_ack     = 1'b0;

        vecs[0]  = mk(1, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 32'h0, B0);
        vecs[1]  = mk(0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 32'h0, B0);
        vecs[2]  = mk(0, 2'b01, 2'b00, 0, 1, 0, 2'b00, 1, L0, B0);
        vecs[3]  = mk(0, 2'b01, 2'b00, 0, 1, 0, 2'b00, 1, L0, B0);
        vecs[4]  = mk(0, 2'b01, 2'b00, 1, 0, 0, 2'b01, 1, L0, B0);
        vecs[5]  = mk(0, 2'b00, 2'b00, 1, 0, 0, 2'b01, 1, L0, B0);
        vecs[6]  = mk(0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, L0, B0);
        vecs[7]  = mk(0, 2'b11, 2'b00, 0, 1, 0, 2'b00, 1, L1, B1);
        vecs[8]  = mk(0, 2'b11, 2'b00, 1, 0, 0, 2'b10, 1, L1, B1);
        vecs[9]  = mk(0, 2'b01, 2'b00, 1, 0, 0, 2'b10, 1, L1, B1);
        vecs[10] = mk(0, 2'b01, 2'b00, 0, 0, 0, 2'b00, 0, L1, B1);
        vecs[11] = mk(0, 2'b01, 2'b00, 0, 1, 0, 2'b00, 1, L0, B0);
        vecs[12] = mk(0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, L0, B0);
        vecs[13] = mk(0, 2'b00, 2'b10, 0, 0, 1, 2'b00, 1, L1, B1);
        vecs[14] = mk(0, 2'b00, 2'b10, 1, 0, 0, 2'b10, 1, L1, B1);
        vecs[15] = mk(0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, L1, B1);
        vecs[16] = mk(0, 2'b01, 2'b01, 0, 1, 0, 2'b00, 1, L0, B0);
        vecs[17] = mk(0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, L0, B0);
        vecs[18] = mk(0, 2'b01, 2'b00, 0, 1, 0, 2'b00, 1, L0, B0);
        vecs[19] = mk(0, 2'b01, 2'b00, 1, 0, 0, 2'b01, 1, L0, B0);
        vecs[20] = mk(0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, L0, B0);
        vecs[21] = mk(0, 2'b10, 2'b00, 0, 1, 0, 2'b00, 1, L1, B1);
        vecs[22] = mk(0, 2'b10, 2'b00, 1, 0, 0, 2'b10, 1, L1, B1);
        vecs[23] = mk(1, 2'b10, 2'b00, 1, 0, 0, 2'b00, 0, 32'h0, B0);
        vecs[24] = mk(0, 2'b11, 2'b00, 0, 1, 0, 2'b00, 1, L0, B0);
        vecs[25] = mk(0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, L0, B0);

        reset4 = 1'b1;
        for (int i = 0; i < 26; i++) begin
            reset2       = vecs[i].rst;
            if2.drv_rd   = vecs[i].rd;
            if2.drv_wr   = vecs[i].wr;
            if2.host_ack = vecs[i].ack;
            tick();
            check($sformatf("vec%0d", i),
                  64'({if2.host_rd, if2.host_wr, if2.drv_ack, if2.busy, if2.host_lba, if2.host_buff_din}),
                  64'({vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_ack, vecs[i].e_busy, vecs[i].e_lba, vecs[i].e_buf}));
        end

        // Long sector: host_ack high for 512 cycles.
        if2.drv_rd = 2'b01;
        tick();
        check("long_grant", 64'({if2.host_rd, if2.host_lba}), 64'({1'b1, L0}));
        if2.host_ack = 1'b1;
        #1;
        check("long_ack_delay", 64'(if2.drv_ack), 64'(2'b00));
        errs = 0;
        for (int i = 0; i < 512; i++) begin
            tick();
            if (i == 0) if2.drv_rd = 2'b00;
            if (if2.drv_ack !== 2'b01 || if2.host_rd !== 1'b0) errs++;
        end
        check("long_ack_hold_errs", 64'(errs), 64'd0);
        if2.host_ack = 1'b0;
        tick();
        check("long_end", 64'({if2.drv_ack, if2.busy}), 64'd0);

        // NDR=4 instance.
        tick();
        reset4 = 1'b0;
        check("r4_reset", 64'({if4.host_rd, if4.host_wr, if4.drv_ack, if4.busy, if4.host_lba}), 64'd0);

        if4.drv_wr = 4'b1111;
        for (int g = 0; g < 4; g++) begin
            serve4(1'b1, idx);
            check($sformatf("rr_drop_grant%0d", g), 64'(idx), 64'(g));
        end
        if4.drv_wr = 4'b1111;
        for (int g = 0; g < 4; g++) begin
            serve4(1'b0, idx);
            check($sformatf("rr_held_grant%0d", g), 64'(idx), 64'(g));
        end
        if4.drv_wr = 4'b0000;
        tick();
        check("rr_overlap", 64'(overlap), 64'd0);
        check("rr_idle", 64'({if4.busy, if4.host_wr}), 64'd0);

        // Buffer mux: drive 2 byte must show through REQ and XFER.
        if4.drv_rd = 4'b0100;
        tick();
        errs = 0;
        for (int i = 0; i < 3; i++) begin
            if (if4.host_buff_din !== 8'hC2 || if4.host_rd !== 1'b1) errs++;
            tick();
        end
        if4.host_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (if4.host_buff_din !== 8'hC2 || if4.drv_ack !== 4'b0100) errs++;
        end
        check("buf_mux_errs", 64'(errs), 64'd0);
        if4.drv_rd   = 4'b0000;
        if4.host_ack = 1'b0;
        tick();

        // Cancel: rr_ptr is now 3, so drive 1 is reached via 3,0,1.
        if4.drv_rd = 4'b0010;
        tick();
        check("cancel_grant", 64'({if4.host_rd, if4.host_lba}), 64'({1'b1, 32'h101}));
        if4.drv_rd = 4'b0000;
        tick();
        check("cancel_drop", 64'({if4.host_rd, if4.busy, if4.drv_ack}), 64'd0);

        // Timeout: request held, host never answers.
        if4.drv_rd = 4'b0001;
        tick();
        check("tmo_grant", 64'({if4.host_rd, if4.host_lba}), 64'({1'b1, 32'h100}));
        cnt = 0;
        while (if4.host_rd && cnt < 40) begin
            tick();
            cnt++;
        end
        check("tmo_cycles", 64'(cnt), 64'd16);
        check("tmo_idle", 64'({if4.busy, if4.drv_ack}), 64'd0);
        tick();
        check("tmo_regrant", 64'({if4.host_rd, if4.host_lba}), 64'({1'b1, 32'h100}));
        if4.drv_rd = 4'b0000;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
